rv_mc_controller: RTL and testbench

Multi-cycle RV32I control unit: the sequential successor of the single-cycle main decoder. An explicit state machine sequences fetch, decode, execute, memory and writeback over several cycles against a shared instruction/data memory that uses a ready handshake. It adds on-chip branch-condition evaluation, illegal-instruction and bus-timeout traps, and an optional performance-counter bank. It sits between the instruction register and the multi-cycle datapath (PC, IR, old-PC, ALU-out and data registers).

---
 rtl/rv_ctrl_pkg.sv | 67 ++++++
 rtl/rv_branch_cond.sv | 26 ++
 rtl/rv_mc_controller.sv | 256 +++++++++++++++++++++++++
 tb/tb_rv_mc_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// datapath mux selects and trap causes.
package rv_ctrl_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/rv_branch_cond.sv
// Branch condition evaluation: funct3 selects which ALU flag decides the take;
// funct3 010/011 are not branches and are flagged illegal.
module rv_branch_cond (
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       take_o,
  output logic       illegal_o
);

  always_comb begin
    take_o    = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      3'b000:         take_o = zero_i;
      3'b001:         take_o = ~zero_i;
      3'b100:         take_o = lt_i;
      3'b101:         take_o = ~lt_i;
      3'b110:         take_o = ltu_i;
      3'b111:         take_o = ~ltu_i;
      default:        illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_mc_controller.sv
// Multi-cycle RV32I control FSM with branch evaluation, illegal/bus-timeout traps.
// Define RV_MC_PERF_EN to add the cycle_cnt/instret_cnt performance counters.
module rv_mc_controller
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       mem_funct3,
  output logic             adr_src,
  output logic             pc_write,
  output logic             ir_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             reg_write,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       state_o
`ifdef RV_MC_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_store, in_mem, timeout, br_take, br_illegal;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_store = (opcode == OP_STORE);
  assign in_mem   = is_mem_state(state_q);
  assign timeout  = (MEM_TIMEOUT != 0) && in_mem && (wait_q == WAIT_W'(MEM_TIMEOUT));

  rv_branch_cond u_branch_cond (
    .funct3_i  (funct3),
    .zero_i    (alu_zero),
    .lt_i      (alu_lt),
    .ltu_i     (alu_ltu),
    .take_o    (br_take),
    .illegal_o (br_illegal)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = CAUSE_BUS;
    end else begin
      case (state_q)
        S_FETCH:    if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXEC_R;
            OP_I:              state_d = S_EXEC_I;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            OP_AUIPC:          state_d = S_AUIPC;
            default: begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          endcase
        end
        S_MEMADR:   state_d = is_store ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
        S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
        S_EXEC_R, S_EXEC_I, S_JAL, S_AUIPC: state_d = S_ALUWB;
        S_JALR:     state_d = S_LINK;
        S_BRANCH: begin
          if (br_illegal) begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_ALUWB, S_MEMWB, S_LINK, S_LUI: state_d = S_FETCH;
        default:    state_d = state_q;
      endcase
    end
  end

  // Wait counter restarts whenever the state changes, so each memory state gets a fresh budget.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (in_mem && !mem_ready && (MEM_TIMEOUT != 0)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_funct3 = 3'b010;
    adr_src    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    imm_src    = IMM_I;
    result_src = RES_ALUOUT;
    reg_write  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = is_store ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        mem_funct3 = funct3;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        adr_src    = 1'b1;
        mem_funct3 = funct3;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        pc_write  = br_take;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
      end
      S_LINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
      end
      S_LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMM;
        reg_write  = 1'b1;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
      end
      default: ;
    endcase
    // A timed-out access is abandoned without committing anything.
    if (timeout) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      pc_write = 1'b0;
      ir_write = 1'b0;
    end
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign trap       = (state_q == S_TRAP) && !rst;
  assign trap_cause = rst ? CAUSE_NONE : cause_q;
  assign state_o    = state_q;

`ifdef RV_MC_PERF_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_q <= cycle_q + CNT_W'(1);
      if ((state_d == S_FETCH) && (state_q != S_FETCH)) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_rv_mc_controller.sv
// Directed bench for rv_mc_controller: a phase-level model of each instruction class
// predicts the control outputs, compared every cycle, plus literal cycle/trap pins.
module tb_rv_mc_controller;
  import rv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        alu_zero, alu_lt, alu_ltu, mem_ready;
  logic        mem_req, mem_we, adr_src, pc_write, ir_write, reg_write, trap;
  logic [2:0]  mem_funct3, imm_src;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
  logic [3:0]  state_o;
`ifdef RV_MC_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  rv_mc_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt),
    .alu_ltu    (alu_ltu),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .adr_src    (adr_src),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .result_src (result_src),
    .reg_write  (reg_write),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state_o    (state_o)
`ifdef RV_MC_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0] st;
    logic       req, we;
    logic [2:0] f3;
    logic       adr, pcw, irw;
    logic [1:0] a, b, op;
    logic [2:0] imm;
    logic [1:0] res;
    logic       rw, trp;
    logic [1:0] cause;
  } ctl_t;

  ctl_t act;
  assign act = {state_o, mem_req, mem_we, mem_funct3, adr_src, pc_write, ir_write,
                alu_src_a, alu_src_b, alu_op, imm_src, result_src, reg_write, trap, trap_cause};

  int checks = 0, failures = 0;
  int ncyc = 0, nrw = 0, nir = 0, ntrap = 0, last_rw = 0, last_pcw = 0;

  // Expected outputs of one cycle, from the per-state table; fields the table leaves open are masked.
  function automatic void model(input state_e ph, input logic [31:0] ins, input logic rdy,
                                input logic in_rst, input logic tmo, input logic [1:0] tc,
                                output ctl_t e, output ctl_t m);
    logic [2:0] f3;
    logic       take;
    f3 = ins[14:12];
    case (f3)
      3'b000:  take = alu_zero;
      3'b001:  take = !alu_zero;
      3'b100:  take = alu_lt;
      3'b101:  take = !alu_lt;
      3'b110:  take = alu_ltu;
      3'b111:  take = !alu_ltu;
      default: take = 1'b0;
    endcase
    e = '0;
    m = '0;
    e.st = ph;
    m.st = '1; m.req = 1'b1; m.we = 1'b1; m.pcw = 1'b1; m.irw = 1'b1; m.rw = 1'b1; m.trp = 1'b1;
    if (in_rst) begin
      m.cause = '1;
      return;
    end
    case (ph)
      S_FETCH: begin
        m.a = '1; m.b = '1; m.res = '1; e.b = 2'b10; e.res = 2'b10;
        if (tmo) begin
          m.req = 1'b0; m.we = 1'b0;
        end else begin
          e.req = 1'b1; m.adr = 1'b1; m.f3 = '1; e.f3 = 3'b010;
          e.irw = rdy; e.pcw = rdy;
        end
      end
      S_DECODE:   begin m.a = '1; m.b = '1; m.imm = '1; e.a = 2'b01; e.b = 2'b01; e.imm = 3'b010; end
      S_MEMADR: begin
        m.a = '1; m.b = '1; m.imm = '1; e.a = 2'b10; e.b = 2'b01;
        e.imm = (ins[6:0] == 7'b0100011) ? 3'b001 : 3'b000;
      end
      S_MEMREAD:  begin e.req = 1'b1; m.adr = 1'b1; e.adr = 1'b1; m.f3 = '1; e.f3 = f3; end
      S_MEMWB:    begin m.res = '1; e.res = 2'b01; e.rw = 1'b1; end
      S_MEMWRITE: begin e.req = 1'b1; e.we = 1'b1; m.adr = 1'b1; e.adr = 1'b1; m.f3 = '1; e.f3 = f3; end
      S_EXEC_R:   begin m.a = '1; m.b = '1; m.op = '1; e.a = 2'b10; e.b = 2'b00; e.op = 2'b10; end
      S_EXEC_I:   begin m.a = '1; m.b = '1; m.op = '1; e.a = 2'b10; e.b = 2'b01; e.op = 2'b10; end
      S_ALUWB:    begin m.res = '1; e.res = 2'b00; e.rw = 1'b1; end
      S_BRANCH: begin
        m.a = '1; m.b = '1; m.op = '1; m.res = '1;
        e.a = 2'b10; e.b = 2'b00; e.op = 2'b01; e.res = 2'b00; e.pcw = take;
      end
      S_JAL:      begin m.a = '1; m.b = '1; m.res = '1; e.a = 2'b01; e.b = 2'b10; e.res = 2'b00; e.pcw = 1'b1; end
      S_JALR:     begin m.a = '1; m.b = '1; m.res = '1; e.a = 2'b10; e.b = 2'b01; e.res = 2'b10; e.pcw = 1'b1; end
      S_LINK:     begin m.a = '1; m.b = '1; m.res = '1; e.a = 2'b01; e.b = 2'b10; e.res = 2'b10; e.rw = 1'b1; end
      S_LUI:      begin m.imm = '1; m.res = '1; e.imm = 3'b100; e.res = 2'b11; e.rw = 1'b1; end
      S_AUIPC:    begin m.a = '1; m.b = '1; m.imm = '1; e.a = 2'b01; e.b = 2'b01; e.imm = 3'b100; end
      S_TRAP:     begin e.trp = 1'b1; m.cause = '1; e.cause = tc; end
      default: ;
    endcase
  endfunction

  task automatic cyc(input state_e ph, input logic rdy, input logic r, input logic tmo, input logic [1:0] tc);
    ctl_t e, m;
    mem_ready = rdy;
    rst       = r;
    model(ph, instr, rdy, r, tmo, tc, e, m);
    @(negedge clk);
    checks++;
    if (((act ^ e) & m) != '0) begin
      failures++;
      $display("FAIL ctl[%s] instr=%h got=%h want=%h mask=%h", ph.name(), instr, act, e, m);
    end
    ncyc++;
    if (reg_write) begin nrw++; last_rw = ncyc; end
    if (pc_write) last_pcw = ncyc;
    if (ir_write) nir++;
    if (trap) ntrap++;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Phase sequence of one instruction, by class; dw = mem_ready=0 cycles in its data access.
  task automatic run_instr(input string tag, input logic [31:0] ins, input int dw,
                           input logic z, input logic l, input logic lu, output int len);
    int c0;
    instr = ins; alu_zero = z; alu_lt = l; alu_ltu = lu;
    c0 = ncyc;
    cyc(S_FETCH, 1'b1, 1'b0, 1'b0, 2'b00);
    cyc(S_DECODE, 1'b1, 1'b0, 1'b0, 2'b00);
    case (ins[6:0])
      7'b0000011: begin
        cyc(S_MEMADR, 1'b0, 1'b0, 1'b0, 2'b00);
        repeat (dw) cyc(S_MEMREAD, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(S_MEMREAD, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc(S_MEMWB, 1'b1, 1'b0, 1'b0, 2'b00);
      end
      7'b0100011: begin
        cyc(S_MEMADR, 1'b1, 1'b0, 1'b0, 2'b00);
        repeat (dw) cyc(S_MEMWRITE, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(S_MEMWRITE, 1'b1, 1'b0, 1'b0, 2'b00);
      end
      7'b0110011: begin cyc(S_EXEC_R, 1'b1, 1'b0, 1'b0, 2'b00); cyc(S_ALUWB, 1'b0, 1'b0, 1'b0, 2'b00); end
      7'b0010011: begin cyc(S_EXEC_I, 1'b0, 1'b0, 1'b0, 2'b00); cyc(S_ALUWB, 1'b1, 1'b0, 1'b0, 2'b00); end
      7'b1100011: begin
        cyc(S_BRANCH, 1'b1, 1'b0, 1'b0, 2'b00);
        if (ins[14:12] inside {3'b010, 3'b011}) cyc(S_TRAP, 1'b1, 1'b0, 1'b0, 2'b01);
      end
      7'b1101111: begin cyc(S_JAL, 1'b1, 1'b0, 1'b0, 2'b00); cyc(S_ALUWB, 1'b1, 1'b0, 1'b0, 2'b00); end
      7'b1100111: begin cyc(S_JALR, 1'b0, 1'b0, 1'b0, 2'b00); cyc(S_LINK, 1'b1, 1'b0, 1'b0, 2'b00); end
      7'b0110111: cyc(S_LUI, 1'b1, 1'b0, 1'b0, 2'b00);
      7'b0010111: begin cyc(S_AUIPC, 1'b1, 1'b0, 1'b0, 2'b00); cyc(S_ALUWB, 1'b1, 1'b0, 1'b0, 2'b00); end
      default:    cyc(S_TRAP, 1'b1, 1'b0, 1'b0, 2'b01);
    endcase
    len = ncyc - c0;
    $display("txn %-10s instr=%h cycles=%0d trap=%0b cause=%0d", tag, ins, len, trap, trap_cause);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int len, rw0, ir0, tr0;
    rst = 1'b1; mem_ready = 1'b0; instr = 32'h0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    @(posedge clk);
    #1;
    cyc(S_FETCH, 1'b1, 1'b1, 1'b0, 2'b00);
    cyc(S_FETCH, 1'b1, 1'b1, 1'b0, 2'b00);

    rw0 = nrw;
    run_instr("add", 32'h00208033, 0, 1'b0, 1'b0, 1'b0, len);
    lit("add_cycles", len, 4);
    lit("add_rw_count", nrw - rw0, 1);
    lit("add_rw_last_cycle", last_rw - (ncyc - len), 4);
`ifdef RV_MC_PERF_EN
    lit("perf_instret", int'(instret_cnt), 1);
    lit("perf_cycle", int'(cycle_cnt), 4);
`endif
    run_instr("addi", 32'h00500093, 0, 1'b0, 1'b0, 1'b0, len);
    lit("addi_cycles", len, 4);
    run_instr("lw", 32'h00012083, 3, 1'b0, 1'b0, 1'b0, len);
    lit("lw_cycles", len, 8);
    run_instr("sw", 32'h00112223, 2, 1'b0, 1'b0, 1'b0, len);
    lit("sw_cycles", len, 6);
    run_instr("bne_take", 32'h00209463, 0, 1'b0, 1'b0, 1'b0, len);
    lit("bne_take_pcw_cycle", last_pcw - (ncyc - len), 3);
    run_instr("bne_fall", 32'h00209463, 0, 1'b1, 1'b0, 1'b0, len);
    lit("bne_fall_pcw_cycle", last_pcw - (ncyc - len), 1);
    lit("bne_cycles", len, 3);
    run_instr("blt_take", 32'h0020C463, 0, 1'b0, 1'b1, 1'b0, len);
    run_instr("bgeu_fall", 32'h0020F463, 0, 1'b0, 1'b0, 1'b1, len);
    run_instr("beq_take", 32'h00208463, 0, 1'b1, 1'b0, 1'b0, len);
    run_instr("jal", 32'h008000EF, 0, 1'b0, 1'b0, 1'b0, len);
    lit("jal_cycles", len, 4);
    run_instr("jalr", 32'h000080E7, 0, 1'b0, 1'b0, 1'b0, len);
    lit("jalr_cycles", len, 4);
    run_instr("lui", 32'h123450B7, 0, 1'b0, 1'b0, 1'b0, len);
    lit("lui_cycles", len, 3);
    run_instr("auipc", 32'h00001097, 0, 1'b0, 1'b0, 1'b0, len);
    lit("auipc_cycles", len, 4);

    // funct3=010 on the branch opcode is illegal
    run_instr("br_f3_010", 32'h0020A463, 0, 1'b0, 1'b0, 1'b0, len);
    lit("br_illegal_trap", int'(trap), 1);
    lit("br_illegal_cause", int'(trap_cause), 1);
    lit("br_illegal_no_pcw", last_pcw - (ncyc - len), 1);
    cyc(S_TRAP, 1'b1, 1'b1, 1'b0, 2'b00);

    // illegal opcode: trap is absorbing until reset
    run_instr("op_7f", 32'h0000007F, 0, 1'b0, 1'b0, 1'b0, len);
    tr0 = ntrap;
    for (int i = 0; i < 20; i++) cyc(S_TRAP, i[0], 1'b0, 1'b0, 2'b01);
    lit("trap_persist", ntrap - tr0, 20);
    cyc(S_TRAP, 1'b1, 1'b1, 1'b0, 2'b00);
    lit("trap_cleared", int'(trap), 0);
    lit("state_after_rst", int'(state_o), int'(S_FETCH));

    // bus watchdog in FETCH: 4 unanswered cycles, then a timeout cycle, then TRAP cause 10
    ir0 = nir;
    instr = 32'h00208033;
    repeat (4) cyc(S_FETCH, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(S_FETCH, 1'b0, 1'b0, 1'b1, 2'b00);
    repeat (3) cyc(S_TRAP, 1'b0, 1'b0, 1'b0, 2'b10);
    lit("timeout_cause", int'(trap_cause), 2);
    lit("timeout_no_ir_write", nir - ir0, 0);
    $display("txn %-10s instr=%h trap=%0b cause=%0d", "timeout", instr, trap, trap_cause);
    cyc(S_TRAP, 1'b0, 1'b1, 1'b0, 2'b00);

    // reset in the middle of a store wait
    rw0 = nrw;
    instr = 32'h00112223;
    cyc(S_FETCH, 1'b1, 1'b0, 1'b0, 2'b00);
    cyc(S_DECODE, 1'b1, 1'b0, 1'b0, 2'b00);
    cyc(S_MEMADR, 1'b1, 1'b0, 1'b0, 2'b00);
    repeat (2) cyc(S_MEMWRITE, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(S_MEMWRITE, 1'b0, 1'b1, 1'b0, 2'b00);
    cyc(S_FETCH, 1'b0, 1'b0, 1'b0, 2'b00);
    lit("rst_memwrite_no_rw", nrw - rw0, 0);
    $display("txn %-10s instr=%h state=%0d", "sw_rst", instr, state_o);

    run_instr("add_after", 32'h00208033, 0, 1'b0, 1'b0, 1'b0, len);
    lit("add_after_cycles", len, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
